// File: rtl/aes_axis_packer_32to128.sv
// Packs a narrow AXI-Stream into 128-bit blocks, zero-padding the final block.
// Optional handshake statistics are enabled by defining AES_PACKER_STATS_EN.
module aes_axis_packer_32to128 #(
  parameter int S_DATA_WIDTH = 32,
  parameter int STAT_WIDTH   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [S_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [S_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  output logic [127:0]              m_axis_tdata,
  output logic [15:0]               m_axis_tkeep,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic [STAT_WIDTH-1:0]     stat_blocks,
  output logic [STAT_WIDTH-1:0]     stat_packets
);

  localparam int RATIO = 128 / S_DATA_WIDTH;
  localparam int KW    = S_DATA_WIDTH / 8;
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  logic [CW-1:0]  cnt_q;
  logic [127:0]   acc_data_q;
  logic [15:0]    acc_keep_q;
  logic           out_valid_q;
  logic [127:0]   out_data_q;
  logic [15:0]    out_keep_q;
  logic           out_last_q;

  logic [127:0]   ins_data;
  logic [15:0]    ins_keep;
  logic           accept;
  logic           complete;

  // Place the current beat in its slot; slot 0 holds the MSBs.
  always_comb begin
    ins_data = '0;
    ins_keep = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (cnt_q == k[CW-1:0]) begin
        ins_data[127-k*S_DATA_WIDTH -: S_DATA_WIDTH] = s_axis_tdata;
        ins_keep[15-k*KW -: KW] = s_axis_tkeep;
      end
    end
  end

  assign s_axis_tready = !rst && (!out_valid_q || m_axis_tready ||
                         (cnt_q != LAST && !s_axis_tlast));
  assign accept   = s_axis_tvalid && s_axis_tready;
  assign complete = accept && (cnt_q == LAST || s_axis_tlast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_data_q  <= '0;
      acc_keep_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      if (complete) begin
        out_valid_q <= 1'b1;
        out_data_q  <= acc_data_q | ins_data;
        out_keep_q  <= acc_keep_q | ins_keep;
        out_last_q  <= s_axis_tlast;
        cnt_q       <= '0;
        acc_data_q  <= '0;
        acc_keep_q  <= '0;
      end else begin
        if (accept) begin
          cnt_q      <= cnt_q + CW'(1);
          acc_data_q <= acc_data_q | ins_data;
          acc_keep_q <= acc_keep_q | ins_keep;
        end
        if (out_valid_q && m_axis_tready) out_valid_q <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = out_data_q;
  assign m_axis_tkeep  = out_keep_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tlast  = out_last_q;

`ifdef AES_PACKER_STATS_EN
  logic [STAT_WIDTH-1:0] stat_blocks_q;
  logic [STAT_WIDTH-1:0] stat_packets_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_blocks_q  <= '0;
      stat_packets_q <= '0;
    end else if (out_valid_q && m_axis_tready) begin
      stat_blocks_q <= stat_blocks_q + STAT_WIDTH'(1);
      if (out_last_q) stat_packets_q <= stat_packets_q + STAT_WIDTH'(1);
    end
  end

  assign stat_blocks  = stat_blocks_q;
  assign stat_packets = stat_packets_q;
`else
  assign stat_blocks  = '0;
  assign stat_packets = '0;
`endif

endmodule

// File: tb/tb_aes_axis_packer_32to128.sv
// Randomized and directed bench for the 32->128 AXI-Stream block packer.
// Expected blocks come from a byte-concatenation model of accepted beats.
module tb_aes_axis_packer_32to128;

  localparam int SW    = 32;
  localparam int KW    = SW / 8;
  localparam int RATIO = 128 / SW;
  localparam int STW   = 32;

  typedef struct {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
  } blk_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [SW-1:0]  s_tdata = '0;
  logic [KW-1:0]  s_tkeep = '0;
  logic           s_valid = 1'b0;
  logic           s_tlast = 1'b0;
  logic           s_ready;
  logic [127:0]   m_data;
  logic [15:0]    m_keep;
  logic           m_valid;
  logic           m_last;
  logic           m_ready = 1'b1;
  logic [STW-1:0] stat_blocks;
  logic [STW-1:0] stat_packets;

  int total = 0;
  int bad   = 0;
  int mr_mode = 0;

  aes_axis_packer_32to128 #(.S_DATA_WIDTH(SW), .STAT_WIDTH(STW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
    .s_axis_tvalid(s_valid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_ready),
    .m_axis_tdata(m_data), .m_axis_tkeep(m_keep),
    .m_axis_tvalid(m_valid), .m_axis_tlast(m_last),
    .m_axis_tready(m_ready),
    .stat_blocks(stat_blocks), .stat_packets(stat_packets)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (mr_mode)
      0: m_ready = 1'b1;
      1: m_ready = 1'b0;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model state
  blk_t         mq[$];
  int           n = 0;
  logic [127:0] md = '0;
  logic [15:0]  mk = '0;
  bit           load_pend = 0;
  bit           was_stall = 0;
  blk_t         held;
  blk_t         last_seen;
  int           blocks_seen = 0;
  int           hs_b = 0;
  int           hs_p = 0;
  bit           cont_mode = 0;
  int           rdy_low = 0;

  always @(negedge clk) begin
    blk_t e;
    if (rst) begin
      mq.delete();
      n = 0; md = '0; mk = '0;
      load_pend = 0; was_stall = 0;
      hs_b = 0; hs_p = 0;
    end else begin
      if (load_pend) chk("latency", 128'(m_valid), 128'd1);
      load_pend = 0;
      chk("s_ready", 128'(s_ready),
          128'(!m_valid || m_ready || (n != RATIO - 1 && !s_tlast)));
      if (cont_mode && !s_ready) rdy_low++;
      if (was_stall) begin
        chk("hold_valid", 128'(m_valid), 128'd1);
        chk("hold_data", m_data, held.d);
        chk("hold_keep", 128'(m_keep), 128'(held.k));
        chk("hold_last", 128'(m_last), 128'(held.l));
      end
      was_stall = m_valid && !m_ready;
      held.d = m_data; held.k = m_keep; held.l = m_last;
      if (m_valid && m_ready) begin
        if (mq.size() == 0) begin
          chk("spurious", 128'(m_valid), 128'd0);
        end else begin
          e = mq.pop_front();
          chk("blk_data", m_data, e.d);
          chk("blk_keep", 128'(m_keep), 128'(e.k));
          chk("blk_last", 128'(m_last), 128'(e.l));
        end
        last_seen.d = m_data; last_seen.k = m_keep; last_seen.l = m_last;
        blocks_seen++;
        hs_b++;
        if (m_last) hs_p++;
      end
      if (s_valid && s_ready) begin
        md = md | (128'(s_tdata) << (128 - SW * (n + 1)));
        mk = mk | (16'(s_tkeep) << (16 - KW * (n + 1)));
        n++;
        if (s_tlast || n == RATIO) begin
          e.d = md; e.k = mk; e.l = s_tlast;
          mq.push_back(e);
          n = 0; md = '0; mk = '0;
          load_pend = 1;
        end
      end
    end
  end

  task automatic beat(input logic [SW-1:0] d, input logic [KW-1:0] k,
                      input logic l);
    bit got;
    int t;
    s_tdata = d; s_tkeep = k; s_tlast = l; s_valid = 1'b1;
    got = 0; t = 0;
    do begin
      @(negedge clk);
      got = s_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!got && t < 500);
    s_valid = 1'b0; s_tlast = 1'b0;
    if (!got) chk("beat_timeout", 128'(got), 128'd1);
  endtask

  task automatic send_pkt(input int nb, input logic [KW-1:0] lk);
    for (int i = 0; i < nb; i++)
      beat($urandom, (i == nb - 1) ? lk : {KW{1'b1}}, i == nb - 1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((mq.size() != 0 || m_valid) && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain", 128'(mq.size() != 0 || m_valid), 128'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int b0;
    logic [127:0] exp_d;
    // reset values
    @(negedge clk);
    chk("rst_tvalid", 128'(m_valid), 128'd0);
    chk("rst_tlast", 128'(m_last), 128'd0);
    chk("rst_tdata", m_data, 128'd0);
    chk("rst_tkeep", 128'(m_keep), 128'd0);
    chk("rst_tready", 128'(s_ready), 128'd0);
    chk("rst_stat_b", 128'(stat_blocks), 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // NIST plaintext block
    b0 = blocks_seen;
    beat(32'h6BC1BEE2, 4'hF, 1'b0);
    beat(32'h2E409F96, 4'hF, 1'b0);
    beat(32'hE93D7E11, 4'hF, 1'b0);
    beat(32'h7393172A, 4'hF, 1'b1);
    @(negedge clk);
    chk("nist_valid", 128'(m_valid), 128'd1);
    drain();
    chk("nist_count", 128'(blocks_seen - b0), 128'd1);
    chk("nist_data", last_seen.d, 128'h6BC1BEE22E409F96E93D7E117393172A);
    chk("nist_keep", 128'(last_seen.k), 128'hFFFF);
    chk("nist_last", 128'(last_seen.l), 128'd1);

    // continuous 64 beats, tlast every 16th
    b0 = blocks_seen;
    rdy_low = 0;
    cont_mode = 1;
    for (int i = 0; i < 64; i++)
      beat($urandom, 4'hF, (i % 16) == 15);
    cont_mode = 0;
    drain();
    chk("cont_ready_low", 128'(rdy_low), 128'd0);
    chk("cont_blocks", 128'(blocks_seen - b0), 128'd16);

    // 6-beat packet with partial last beat
    b0 = blocks_seen;
    beat(32'hAE2D8A57, 4'hF, 1'b0);
    beat(32'h1E03AC9C, 4'hF, 1'b0);
    beat(32'h9EB76FAC, 4'hF, 1'b0);
    beat(32'h45AF8E51, 4'hF, 1'b0);
    beat(32'h30C81C46, 4'hF, 1'b0);
    beat(32'hAABBCCDD, 4'b1100, 1'b1);
    drain();
    exp_d = {32'h30C81C46, 32'hAABBCCDD, 64'd0};
    chk("pad_count", 128'(blocks_seen - b0), 128'd2);
    chk("pad_data", last_seen.d, exp_d);
    chk("pad_keep", 128'(last_seen.k), 128'hFC00);
    chk("pad_last", 128'(last_seen.l), 128'd1);

    // tlast beat with empty keep on a full-slot boundary
    beat(32'h01020304, 4'hF, 1'b0);
    beat(32'h05060708, 4'h0, 1'b1);
    drain();
    chk("k0_keep", 128'(last_seen.k), 128'hF000);
    chk("k0_data", last_seen.d, {64'h0102030405060708, 64'd0});

    // downstream stall for 20 cycles mid-stream
    b0 = blocks_seen;
    mr_mode = 1;
    fork
      for (int p = 0; p < 3; p++) send_pkt(4, 4'hF);
      begin
        repeat (20) @(posedge clk);
        #1;
        mr_mode = 0;
      end
    join
    drain();
    chk("stall_blocks", 128'(blocks_seen - b0), 128'd3);

    // reset mid-packet
    beat(32'hDEADBEEF, 4'hF, 1'b0);
    beat(32'hCAFEF00D, 4'hF, 1'b0);
    do_reset();
    b0 = blocks_seen;
    beat(32'h11111111, 4'hF, 1'b0);
    beat(32'h22222222, 4'hF, 1'b0);
    beat(32'h33333333, 4'hF, 1'b0);
    beat(32'h44444444, 4'hF, 1'b1);
    drain();
    chk("rstmid_count", 128'(blocks_seen - b0), 128'd1);
    chk("rstmid_data", last_seen.d, 128'h11111111222222223333333344444444);

    // random packets with random backpressure
    mr_mode = 2;
    for (int p = 0; p < 30; p++)
      send_pkt($urandom_range(1, 9), 4'($urandom_range(0, 15)));
    mr_mode = 0;
    drain();

    // statistics over 3 packets of 8 beats
    do_reset();
    for (int p = 0; p < 3; p++) send_pkt(8, 4'hF);
    drain();
    @(negedge clk);
`ifdef AES_PACKER_STATS_EN
    chk("stat_blocks", 128'(stat_blocks), 128'(hs_b));
    chk("stat_packets", 128'(stat_packets), 128'(hs_p));
    chk("stat_b6", 128'(hs_b), 128'd6);
`else
    chk("stat_blocks", 128'(stat_blocks), 128'd0);
    chk("stat_packets", 128'(stat_packets), 128'd0);
    chk("stat_b6", 128'(hs_b), 128'd6);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
